// File: rtl/rf_access_ctrl_if.sv
// rf_access_ctrl_if: command/response handshake bundle between a sequencer and rf_access_ctrl
interface rf_access_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );
   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: sequences read/write/clear commands onto the register-file pins, one response per command
module rf_access_ctrl #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 4,
   parameter int ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   rf_access_ctrl_if.slave   bus,
   output logic [ADDR_W-1:0] R_Address,
   output logic [ADDR_W-1:0] W_Address,
   output logic              read_enable,
   output logic              write_enable,
   output logic [DATA_W-1:0] WriteData,
   input  logic [DATA_W-1:0] ReadData
);
   typedef enum logic [2:0] {IDLE, WR, RD, RD_CAP, CLR, RESP} state_t;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
   state_t state;
   logic   bad;
   assign bad = bus.cmd_op == 2'b11 || (!bus.cmd_op[1] && bus.cmd_addr > LAST);
   // W_Address doubles as the clear counter while in CLR
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         bus.cmd_ready <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
         R_Address     <= '0;
         W_Address     <= '0;
         read_enable   <= 1'b0;
         write_enable  <= 1'b0;
         WriteData     <= '0;
      end else begin
         case (state)
            IDLE: if (bus.cmd_valid && bus.cmd_ready) begin
               bus.cmd_ready <= 1'b0;
               if (bad) begin
                  state         <= RESP;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_rdata <= '0;
               end else if (bus.cmd_op == 2'b00) begin
                  state       <= RD;
                  read_enable <= 1'b1;
                  R_Address   <= bus.cmd_addr;
               end else if (bus.cmd_op == 2'b01) begin
                  state        <= WR;
                  write_enable <= 1'b1;
                  W_Address    <= bus.cmd_addr;
                  WriteData    <= bus.cmd_wdata;
               end else begin
                  state        <= CLR;
                  write_enable <= 1'b1;
                  W_Address    <= '0;
                  WriteData    <= '0;
               end
            end else begin
               bus.cmd_ready <= 1'b1;
            end
            WR: begin
               state         <= RESP;
               write_enable  <= 1'b0;
               W_Address     <= '0;
               WriteData     <= '0;
               bus.rsp_valid <= 1'b1;
            end
            RD: state <= RD_CAP;
            RD_CAP: begin
               state         <= RESP;
               read_enable   <= 1'b0;
               R_Address     <= '0;
               bus.rsp_rdata <= ReadData;
               bus.rsp_valid <= 1'b1;
            end
            CLR: if (W_Address == LAST) begin
               state         <= RESP;
               write_enable  <= 1'b0;
               W_Address     <= '0;
               bus.rsp_valid <= 1'b1;
            end else begin
               W_Address <= W_Address + 1'b1;
            end
            RESP: if (bus.rsp_ready) begin
               state         <= IDLE;
               bus.rsp_valid <= 1'b0;
               bus.rsp_err   <= 1'b0;
               bus.rsp_rdata <= '0;
               bus.cmd_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
